// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one data-memory port between an instruction-fetch requester and a
//   ld/st queue. Only one request is in flight at a time. Each request goes
//   through three phases: it is granted in IDLE, presented to memory in BUSY
//   until mem_ack, and answered with a one-cycle response strobe in RESP.
//
// Build option:
//   ARB_ROUND_ROBIN_EN - when both requesters are valid, grant the one that was
//                        not granted last. When undefined, ld/st always wins
//                        and fetch may starve.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   f_req_valid/addr/ready           fetch (read-only) request handshake
//   l_req_valid/rw/addr/data/id/ready ld/st request handshake
//   mem_valid/rw/addr/wdata          request presented to the shared port
//   mem_ack, mem_rdata               memory completion and read data
//   f_resp_valid, l_resp_valid       one-cycle response strobes per owner
//   resp_data, resp_id               response payload, held between responses
//   stall_out                        ld/st request pending but not accepted
//
// state | meaning
// IDLE  | no request in flight; grant one requester
// BUSY  | latched request on the memory port, waiting for mem_ack
// RESP  | one-cycle response strobe to the owner
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_req_ready,
  input  logic              l_req_valid,
  input  logic              l_req_rw,
  input  logic [ADDR_W-1:0] l_req_addr,
  input  logic [DATA_W-1:0] l_req_data,
  input  logic [ID_W-1:0]   l_req_id,
  output logic              l_req_ready,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              f_resp_valid,
  output logic              l_resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [ID_W-1:0]   resp_id,
  output logic              stall_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            owner_l;
  logic [ID_W-1:0] lat_id;
  logic            grant_f, grant_l;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_l;  // 1 = ld/st was granted last, 0 = fetch

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_l <= 1'b0;
    else if (l_req_ready)
      last_l <= 1'b1;
    else if (f_req_ready)
      last_l <= 1'b0;
  end

  always_comb begin
    grant_f = 1'b0;
    grant_l = 1'b0;
    if (f_req_valid && l_req_valid) begin
      grant_f = last_l;
      grant_l = !last_l;
    end else begin
      grant_f = f_req_valid;
      grant_l = l_req_valid;
    end
  end
`else
  always_comb begin
    grant_l = l_req_valid;
    grant_f = f_req_valid && !l_req_valid;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; mem_ack only matters in BUSY
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (f_req_valid || l_req_valid) state_nxt = S_BUSY;
      S_BUSY:  if (mem_ack) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; mem_valid follows state so reset drops it at once
  always_comb begin
    f_req_ready  = (state == S_IDLE) && grant_f;
    l_req_ready  = (state == S_IDLE) && grant_l;
    mem_valid    = (state == S_BUSY);
    f_resp_valid = (state == S_RESP) && !owner_l;
    l_resp_valid = (state == S_RESP) && owner_l;
    stall_out    = l_req_valid && !l_req_ready;
  end

  // Request latch and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_id    <= '0;
      owner_l   <= 1'b0;
      resp_data <= '0;
      resp_id   <= '0;
    end else begin
      if (l_req_ready) begin
        mem_rw    <= l_req_rw;
        mem_addr  <= l_req_addr;
        mem_wdata <= l_req_data;
        lat_id    <= l_req_id;
        owner_l   <= 1'b1;
      end else if (f_req_ready) begin
        mem_rw    <= 1'b0;
        mem_addr  <= f_req_addr;
        mem_wdata <= '0;
        lat_id    <= '0;
        owner_l   <= 1'b0;
      end
      // resp_id is loaded here rather than at grant so it holds until the next response
      if ((state == S_BUSY) && mem_ack) begin
        resp_data <= mem_rw ? '0 : mem_rdata;
        resp_id   <= lat_id;
      end
    end
  end

endmodule
